// File: rtl/fp_pkg.sv
// Shared definitions for the fp_* blocks: default pipeline latency, tag FIFO
// depth and the requester-id type carried as a tag.
package fp_pkg;

  localparam int LAT_DEFAULT   = 3;
  localparam int DEPTH_DEFAULT = 4;
  localparam int ID_W          = 1;

  typedef logic [ID_W-1:0] req_id_t;

  localparam req_id_t REQ0 = req_id_t'(0);
  localparam req_id_t REQ1 = req_id_t'(1);

endpackage

// File: rtl/fp_tag_fifo.sv
// Requester-id FIFO tracking which requester owns each in-flight multiply.
// Push is ignored when full and pop is ignored when empty.
module fp_tag_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          pop_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  req_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_id  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP multiplier between two
// requesters, routing each result back to its owner via a tag FIFO.
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ready,
  input  logic [31:0] mul_result,
  input  logic        mul_error,
  output logic        res0_valid,
  output logic [31:0] res0_data,
  output logic        res0_error,
  output logic        res1_valid,
  output logic [31:0] res1_data,
  output logic        res1_error,
  output logic        busy,
  output logic        orphan
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int DRAIN_W = $clog2(LAT + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(LAT + 1);

  logic [DRAIN_W-1:0] drain_cnt;
  logic               draining;
  req_id_t            rr_ptr;
  req_id_t            grant_id;
  req_id_t            pop_id;
  logic               can_accept;
  logic               pick1;
  logic               accept;
  logic               ret_live;
  logic               pop;
  logic               orphan_set;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;

  // The multiplier has no reset, so returns during the drain window belong to
  // operations launched before reset and are dropped silently.
  assign draining = (drain_cnt != '0);

  always_comb begin
    can_accept = !full && !draining;
    pick1      = req1_valid && (!req0_valid || (rr_ptr == REQ1));
    req1_ready = can_accept && pick1;
    req0_ready = can_accept && req0_valid && !pick1;
    accept     = req0_ready || req1_ready;
    grant_id   = req1_ready ? REQ1 : REQ0;
    ret_live   = mul_ready && !draining;
    pop        = ret_live && !empty;
    orphan_set = ret_live && empty;
  end

  assign busy = (count != '0);

  fp_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (grant_id),
    .pop     (pop),
    .pop_id  (pop_id),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt  <= DRAIN_LOAD;
      rr_ptr     <= REQ0;
      mul_valid  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      res0_valid <= 1'b0;
      res0_data  <= '0;
      res0_error <= 1'b0;
      res1_valid <= 1'b0;
      res1_data  <= '0;
      res1_error <= 1'b0;
      orphan     <= 1'b0;
    end else begin
      if (draining) drain_cnt <= drain_cnt - DRAIN_W'(1);
      mul_valid <= accept;
      if (accept) begin
        rr_ptr <= ~grant_id;
        mul_a  <= req1_ready ? req1_a : req0_a;
        mul_b  <= req1_ready ? req1_b : req0_b;
      end
      res0_valid <= pop && (pop_id == REQ0);
      res1_valid <= pop && (pop_id == REQ1);
      if (pop && (pop_id == REQ0)) begin
        res0_data  <= mul_result;
        res0_error <= mul_error;
      end
      if (pop && (pop_id == REQ1)) begin
        res1_data  <= mul_result;
        res1_error <= mul_error;
      end
      if (orphan_set) orphan <= 1'b1;
    end
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 3: cycles from mul_valid high to the matching mul_ready pulse from the shared FP multiply pipeline.
REQ-002 SHALL have parameter DEPTH, default 4: maximum in-flight operations (tag FIFO depth); DEPTH >= LAT+1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: requester n has operands pending.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each: IEEE-754 single operands.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each: operand transfer occurs when valid && ready.
REQ-008 SHALL have ports mul_valid, output, 1, and mul_a / mul_b, output, 32: issue to the multiplier.
REQ-009 SHALL have ports mul_ready, input, 1; mul_result, input, 32; mul_error, input, 1: multiplier return.
REQ-010 SHALL have ports res0_valid / res1_valid, output, 1; res0_data / res1_data, output, 32; res0_error / res1_error, output, 1: routed results.
REQ-011 SHALL have port busy, output, 1: in-flight count non-zero; and orphan, output, 1: sticky result-without-tag flag.

Function
REQ-012 SHALL grant at most one requester per cycle; req_ready is combinational from valid, the round-robin pointer and fifo_full.
REQ-013 SHALL use round-robin: the pointer names the preferred requester; after a grant to n, the pointer moves to the other requester; with a single requester valid, that requester wins.
REQ-014 SHALL deassert both req_ready while the tag FIFO is full or during the drain window (REQ-019).
REQ-015 SHALL register the accepted operands: mul_valid, mul_a and mul_b appear exactly 1 cycle after the accept; mul_valid is a one-cycle pulse per accept, and mul_a / mul_b hold otherwise.
REQ-016 SHALL push the granted requester id (1 bit) into the tag FIFO on accept, and pop on mul_ready; simultaneous push and pop leaves the count unchanged.
REQ-017 SHALL, 1 cycle after mul_ready with a non-empty FIFO, pulse resN_valid for the popped tag N; resN_data = mul_result and resN_error = mul_error, both captured on the mul_ready cycle; the other res_valid stays low.
REQ-018 SHALL, on mul_ready with an empty FIFO outside the drain window, set orphan (sticky until rst), produce no res_valid, and leave the FIFO unchanged.
REQ-019 SHALL open a drain window of LAT+1 cycles after rst deasserts (down-counter): no accepts, and mul_ready is ignored without setting orphan. This covers the multiplier, which has no reset, flushing stale operations.
REQ-020 SHALL give end-to-end latency (accept to res_valid) of LAT+2 cycles.
REQ-021 SHALL assert busy when the FIFO count != 0.

Reset
REQ-022 SHALL, on rst, asynchronously clear: mul_valid, res0_valid, res1_valid, res0_error, res1_error, orphan, FIFO pointers and count, and the RR pointer (prefer requester 0); load the drain counter with LAT+1.
REQ-023 SHALL clear mul_a, mul_b, res0_data and res1_data to 0 on rst.
REQ-024 SHALL, on rst mid-operation, discard all in-flight tags; results of those operations fall in the drain window and are dropped.

Structure
REQ-025 SHALL place the LAT/DEPTH defaults and the requester-id width in the shared package fp_pkg, which the other fp_* blocks also use.
REQ-026 SHALL implement the tag FIFO as sub-module fp_tag_fifo (parameter DEPTH, width 1, async active-high reset, outputs full/empty/count).

Verification
REQ-027 SHALL cover the single-requester case: after the drain window, req0 at a=0x40000000, b=0x40400000 -> mul_valid 1 cycle later; with a mul_ready carrying 0x40C00000 at LAT, res0_valid=1, res0_data=0x40C00000 and res1_valid=0.
REQ-028 SHALL cover contention: both requesters valid for 4 cycles -> grants alternate 0,1,0,1; results return to the same order and owners.
REQ-029 SHALL cover backpressure: hold the model's mul_ready low with DEPTH accepted -> both req_ready=0 and busy=1; one mul_ready -> one further accept next cycle.
REQ-030 SHALL cover an orphan result: a mul_ready pulse with an empty FIFO after the drain window -> orphan=1 and stays 1; no res_valid.
REQ-031 SHALL cover reset mid-flight: rst with 3 tags in flight, then the model returns 3 results inside LAT+1 cycles -> orphan=0, no res_valid, and req_ready stays low until the window ends.
REQ-032 SHALL cover error passthrough: mul_error=1 on a req1 result -> res1_error=1 alongside res1_valid.
